// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the execute stage.
//   - ALUOp field encodings driven by the main decoder
//   - R-type funct codes understood by the ALU control
//   - alu_op_e    : internal ALU operation after ALU-control decode
//   - fwd_sel_e   : operand forwarding source (NONE / EXMEM / MEMWB)
//   - mult_state_e: states of the optional iterative multiplier
//   - alu_decode(): ALUOp + funct -> alu_op_e
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MULT,
    ALU_ZERO
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mult_state_e;

  // ALU control. MULT is only recognised when the multiplier exists;
  // otherwise 0x18 falls into the "unknown funct -> result 0" bucket.
  function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                         input logic [5:0] funct,
                                         input logic       mult_en);
    alu_op_e op;
    case (aluop)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD:  op = ALU_ADD;
          FUNCT_SUB:  op = ALU_SUB;
          FUNCT_AND:  op = ALU_AND;
          FUNCT_OR:   op = ALU_OR;
          FUNCT_NOR:  op = ALU_NOR;
          FUNCT_SLT:  op = ALU_SLT;
          FUNCT_MULT: op = mult_en ? ALU_MULT : ALU_ZERO;
          default:    op = ALU_ZERO;
        endcase
      end
      default: op = ALU_ADD;  // 00 and 11 both add
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_iter_mult.sv
// ---------------------------------------------------------------------------
// ex_iter_mult
// Iterative shift-add multiplier (low DATA_W bits of the unsigned product),
// one multiplier bit per clock, with the stall handshake for the front end.
// Only instantiated when EX_MULT_EN is defined.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   flush_i       abort any multiply, return to IDLE
//   start_i       current EX instruction is MULT
//   a_i, b_i      forwarded operands, captured when the multiply starts
//   stall_o       hold the front end (combinational)
//   busy_o        FSM is in BUSY
//   done_o        FSM is in DONE: product_o is valid this cycle
//   product_o     accumulated product
// ---------------------------------------------------------------------------
module ex_iter_mult
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);

  mult_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MS_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (flush_i) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            state_q  <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          // Multiplicand shifts left while the multiplier shifts right, so
          // bit 0 of mplier_q always selects the correctly weighted addend.
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= MS_DONE;
          end
        end
        MS_DONE: begin
          // The held MULT is still on the inputs here; never restart.
          state_q <= MS_IDLE;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  // The start cycle must already stall, so this cannot wait for BUSY.
  assign stall_o   = !flush_i && (((state_q == MS_IDLE) && start_i) ||
                                  (state_q == MS_BUSY));
  assign busy_o    = (state_q == MS_BUSY);
  assign done_o    = (state_q == MS_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage: forwarding muxes, ALU control, ALU, destination-register
// select and the EX/MEM pipeline register.
// Optional feature macro: EX_MULT_EN (iterative MULT, funct 0x18, stalls
// the front end while it runs). Without it stall_o is tied low.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   flush                synchronous bubble into EX/MEM, aborts a multiply
//   *_in                 ID/EX register outputs (control, operands, indices)
//   wb_*                 MEM/WB write port, used for forwarding
//   stall_o              hold PC, IF/ID and ID/EX this cycle
//   *_out                EX/MEM register outputs
// ---------------------------------------------------------------------------
module ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              RegDst_in,
  input  logic              ALUSrc_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [1:0]        ALUOp_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] SignExt_in,
  input  logic [REG_W-1:0]  Rs_in,
  input  logic [REG_W-1:0]  Rt_in,
  input  logic [REG_W-1:0]  Rd_in,
  input  logic [5:0]        funct_in,
  input  logic              wb_RegWrite,
  input  logic [REG_W-1:0]  wb_WriteReg,
  input  logic [DATA_W-1:0] wb_WriteData,
  output logic              stall_o,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              Zero_out
);

`ifdef EX_MULT_EN
  localparam logic MULT_EN = 1'b1;
`else
  localparam logic MULT_EN = 1'b0;
`endif

  // EX/MEM register
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q, reg_write_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [REG_W-1:0]  wreg_q,      wreg_d;
  logic              zero_q,      zero_d;

  // ------------------------------------------------------------------
  // Forwarding: index 0 is operand A (Rs), index 1 is operand B (Rt).
  // The stage's own EX/MEM register beats MEM/WB; $0 is never forwarded.
  // ------------------------------------------------------------------
  logic [REG_W-1:0]  src_idx [2];
  logic [DATA_W-1:0] rf_val  [2];
  logic [DATA_W-1:0] fwd_val [2];
  fwd_sel_e          fwd_sel [2];

  assign src_idx[0] = Rs_in;
  assign src_idx[1] = Rt_in;
  assign rf_val[0]  = RD1_in;
  assign rf_val[1]  = RD2_in;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (reg_write_q && (wreg_q != '0) && (wreg_q == src_idx[gi])) ? FWD_EXMEM :
      (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == src_idx[gi])) ? FWD_MEMWB :
      FWD_NONE;
    assign fwd_val[gi] = (fwd_sel[gi] == FWD_EXMEM) ? result_q :
                         (fwd_sel[gi] == FWD_MEMWB) ? wb_WriteData :
                         rf_val[gi];
  end

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [REG_W-1:0]  wreg_sel;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_result;

  assign op_a     = fwd_val[0];
  assign fwd_b    = fwd_val[1];
  assign op_b     = ALUSrc_in ? SignExt_in : fwd_b;
  assign wreg_sel = RegDst_in ? Rd_in : Rt_in;
  assign alu_op   = alu_decode(ALUOp_in, funct_in, MULT_EN);

  // ------------------------------------------------------------------
  // ALU. Add/sub wrap silently; slt is a signed compare.
  // ------------------------------------------------------------------
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_NOR: alu_result = ~(op_a | op_b);
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_result = '0;  // ALU_MULT goes through the multiplier
    endcase
  end

`ifdef EX_MULT_EN
  // ------------------------------------------------------------------
  // Iterative multiplier. The EX/MEM fields of the MULT are captured on
  // its first cycle: forwarding sources vanish once EX/MEM holds bubbles.
  // ------------------------------------------------------------------
  logic              mult_stall;
  logic              mult_busy;
  logic              mult_done;
  logic [DATA_W-1:0] mult_product;

  logic              hold_mem_read_q;
  logic              hold_mem_write_q;
  logic              hold_mem_to_reg_q;
  logic              hold_reg_write_q;
  logic [DATA_W-1:0] hold_wdata_q;
  logic [REG_W-1:0]  hold_wreg_q;

  ex_iter_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .start_i   (alu_op == ALU_MULT),
    .a_i       (op_a),
    .b_i       (fwd_b),
    .stall_o   (mult_stall),
    .busy_o    (mult_busy),
    .done_o    (mult_done),
    .product_o (mult_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_mem_read_q   <= 1'b0;
      hold_mem_write_q  <= 1'b0;
      hold_mem_to_reg_q <= 1'b0;
      hold_reg_write_q  <= 1'b0;
      hold_wdata_q      <= '0;
      hold_wreg_q       <= '0;
    end else if (mult_stall && !mult_busy) begin
      hold_mem_read_q   <= MemRead_in;
      hold_mem_write_q  <= MemWrite_in;
      hold_mem_to_reg_q <= MemToReg_in;
      hold_reg_write_q  <= RegWrite_in;
      hold_wdata_q      <= fwd_b;
      hold_wreg_q       <= wreg_sel;
    end
  end

  assign stall_o = mult_stall;
`else
  assign stall_o = 1'b0;
`endif

  // ------------------------------------------------------------------
  // EX/MEM next state. flush wins over everything, including a finishing
  // multiply. Zero follows whatever result is actually loaded.
  // ------------------------------------------------------------------
  always_comb begin
    mem_read_d   = MemRead_in;
    mem_write_d  = MemWrite_in;
    mem_to_reg_d = MemToReg_in;
    reg_write_d  = RegWrite_in;
    result_d     = alu_result;
    wdata_d      = fwd_b;
    wreg_d       = wreg_sel;
`ifdef EX_MULT_EN
    if (mult_done) begin
      mem_read_d   = hold_mem_read_q;
      mem_write_d  = hold_mem_write_q;
      mem_to_reg_d = hold_mem_to_reg_q;
      reg_write_d  = hold_reg_write_q;
      result_d     = mult_product;
      wdata_d      = hold_wdata_q;
      wreg_d       = hold_wreg_q;
    end else if (mult_stall) begin
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      result_d     = '0;
      wdata_d      = '0;
      wreg_d       = '0;
    end
`endif
    if (flush) begin
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      result_d     = '0;
      wdata_d      = '0;
      wreg_d       = '0;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      result_q     <= '0;
      wdata_q      <= '0;
      wreg_q       <= '0;
      zero_q       <= 1'b0;
    end else begin
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      result_q     <= result_d;
      wdata_q      <= wdata_d;
      wreg_q       <= wreg_d;
      zero_q       <= zero_d;
    end
  end

  assign MemRead_out   = mem_read_q;
  assign MemWrite_out  = mem_write_q;
  assign MemToReg_out  = mem_to_reg_q;
  assign RegWrite_out  = reg_write_q;
  assign ALUResult_out = result_q;
  assign WriteData_out = wdata_q;
  assign WriteReg_out  = wreg_q;
  assign Zero_out      = zero_q;

endmodule
